// File: rtl/tag_check_unit.sv
// tag_check_unit: two-stage tag check sitting behind the per-byte tag RAM.
// Stage 1 captures the load request. Stage 2 merges the lane tags returned by
// the tag RAM and checks the merged tag against the clearance register.
// Violations feed a trap request/ack FSM and a saturating violation counter.
// Optional macro TAG_CHECK_STRICT_EN: load_select 3 reports as a violation
// (trap_tag 6'h3F) instead of being silently dropped.

// Per-lane gate: an unused lane contributes zero, even if its tag is X.
module tag_check_lane (
  input  logic       en_i,
  input  logic [5:0] tag_i,
  output logic [5:0] tag_o
);
  assign tag_o = en_i ? tag_i : 6'h00;
endmodule

module tag_check_unit #(
  parameter int         COUNT_W   = 8,
  parameter logic [5:0] CLEAR_RST = 6'h3F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [1:0]         req_load_select,
  input  logic [9:0]         req_addr,
  input  logic [5:0]         tag_in_1,
  input  logic [5:0]         tag_in_2,
  input  logic [5:0]         tag_in_3,
  input  logic [5:0]         tag_in_4,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_clearance,
  output logic               out_valid,
  output logic [5:0]         out_tag,
  output logic               out_violation,
  output logic               trap_req,
  output logic [9:0]         trap_addr,
  output logic [5:0]         trap_tag,
  output logic               trap_overflow,
  input  logic               trap_ack,
  output logic [COUNT_W-1:0] viol_count
);
  localparam int NUM_LANES = 4;
  localparam int TAG_W     = 6;

  typedef enum logic {IDLE = 1'b0, TRAP = 1'b1} state_t;

`ifdef TAG_CHECK_STRICT_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  // Stage-1 request capture
  logic       s1_vld_q, s1_vld_d;
  logic [1:0] s1_sel_q, s1_sel_d;
  logic [9:0] s1_addr_q, s1_addr_d;

  // Configuration and result/trap state
  logic [TAG_W-1:0]   clr_q, clr_d;
  logic               ov_q, ov_d;
  logic [TAG_W-1:0]   otag_q, otag_d;
  logic               oviol_q, oviol_d;
  state_t             state_q, state_d;
  logic               treq_q, treq_d;
  logic [9:0]         taddr_q, taddr_d;
  logic [TAG_W-1:0]   ttag_q, ttag_d;
  logic               tovf_q, tovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // Stage-2 datapath
  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][TAG_W-1:0] lane_tag, lane_gated;
  logic [TAG_W-1:0]                merged;
  logic                            legal, res_vld, viol;
  logic [TAG_W-1:0]                res_tag, hit_bits;

  assign lane_tag = {tag_in_4, tag_in_3, tag_in_2, tag_in_1};

  // Lane enables from the captured load size; illegal size enables nothing
  always_comb begin
    lane_en = '0;
    case (s1_sel_q)
      2'd0:    lane_en = 4'b0001;
      2'd1:    lane_en = 4'b0011;
      2'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tag_check_lane u_lane (
      .en_i  (lane_en[g]),
      .tag_i (lane_tag[g]),
      .tag_o (lane_gated[g])
    );
  end

  // OR-merge the gated lanes into one load tag
  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_LANES; i++) merged = merged | lane_gated[i];
  end

  // Result qualification and violation detection using the current clearance
  always_comb begin
    legal    = (s1_sel_q != 2'd3);
    res_vld  = s1_vld_q && (legal || STRICT);
    res_tag  = legal ? merged : '0;
    hit_bits = legal ? (merged & ~clr_q) : {TAG_W{1'b1}};
    viol     = res_vld && (hit_bits != '0);
  end

  // Next-state for pipeline, counter and trap FSM
  always_comb begin
    s1_vld_d  = req_valid;
    s1_sel_d  = req_valid ? req_load_select : s1_sel_q;
    s1_addr_d = req_valid ? req_addr : s1_addr_q;
    clr_d     = cfg_we ? cfg_clearance : clr_q;
    ov_d      = res_vld;
    otag_d    = res_vld ? res_tag : '0;
    oviol_d   = viol;
    cnt_d     = (viol && cnt_q != {COUNT_W{1'b1}}) ? cnt_q + COUNT_W'(1) : cnt_q;
    state_d   = state_q;
    treq_d    = treq_q;
    taddr_d   = taddr_q;
    ttag_d    = ttag_q;
    tovf_d    = tovf_q;
    case (state_q)
      IDLE: begin
        if (viol) begin
          treq_d  = 1'b1;
          taddr_d = s1_addr_q;
          ttag_d  = hit_bits;
          state_d = TRAP;
        end
      end
      TRAP: begin
        if (trap_ack && viol) begin
          taddr_d = s1_addr_q;
          ttag_d  = hit_bits;
          tovf_d  = 1'b0;
        end else if (trap_ack) begin
          treq_d  = 1'b0;
          tovf_d  = 1'b0;
          state_d = IDLE;
        end else if (viol) begin
          tovf_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_sel_q  <= 2'd0;
      s1_addr_q <= '0;
      clr_q     <= CLEAR_RST;
      ov_q      <= 1'b0;
      otag_q    <= '0;
      oviol_q   <= 1'b0;
      state_q   <= IDLE;
      treq_q    <= 1'b0;
      taddr_q   <= '0;
      ttag_q    <= '0;
      tovf_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sel_q  <= s1_sel_d;
      s1_addr_q <= s1_addr_d;
      clr_q     <= clr_d;
      ov_q      <= ov_d;
      otag_q    <= otag_d;
      oviol_q   <= oviol_d;
      state_q   <= state_d;
      treq_q    <= treq_d;
      taddr_q   <= taddr_d;
      ttag_q    <= ttag_d;
      tovf_q    <= tovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid     = ov_q;
  assign out_tag       = otag_q;
  assign out_violation = oviol_q;
  assign trap_req      = treq_q;
  assign trap_addr     = taddr_q;
  assign trap_tag      = ttag_q;
  assign trap_overflow = tovf_q;
  assign viol_count    = cnt_q;

endmodule

// File: doc/tag_check_unit.md
Name: tag_check_unit

Overview:
- Sits directly downstream of the per-byte tag RAM.
- Captures each load request, then consumes the 6-bit per-byte tags the tag RAM returns one cycle later and merges the valid byte lanes into one load tag.
- Checks the merged tag against a programmable clearance set. Reports violations to the core through a trap request/acknowledge handshake and a saturating violation counter.

Parameters:
- COUNT_W, 8, width of the saturating violation counter.
- CLEAR_RST, 6'h3F, clearance value loaded on reset (all labels cleared, so no violations).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request presented this cycle; same cycle it is presented to the tag RAM.
- req_load_select  in  2  0=byte, 1=halfword, 2=word, 3=illegal.
- req_addr  in  10  byte address of the request.
- tag_in_1 .. tag_in_4  in  6 each  tags from the tag RAM for address, +1, +2, +3; valid the cycle after req_valid.
- cfg_we  in  1  write the clearance register.
- cfg_clearance  in  6  new clearance value.
- out_valid  out  1  merged result valid (single-cycle pulse).
- out_tag  out  6  merged load tag.
- out_violation  out  1  result violates clearance.
- trap_req  out  1  pending violation trap.
- trap_addr  out  10  address of the trapped access.
- trap_tag  out  6  offending bits: merged tag AND NOT clearance.
- trap_overflow  out  1  a further violation occurred while a trap was pending.
- trap_ack  in  1  core acknowledges the trap.
- viol_count  out  COUNT_W  saturating count of all violations.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; clearance = CLEAR_RST; stage-1 valid = 0. Reset mid-operation discards the in-flight request and any pending trap.
- Stage 1 (edge ending cycle N): if req_valid, register valid, load_select and addr; otherwise stage-1 valid = 0.
- Stage 2 (cycle N+1): tag_in_* are valid. Lanes are combined by bitwise OR:
  - byte: tag_in_1 only.
  - halfword: tag_in_1 | tag_in_2.
  - word: all four.
  - Unused lanes are ignored even if X.
- Violation = (merged & ~clearance) != 0, using the clearance value held during cycle N+1.
- Outputs registered at the edge ending N+1: out_valid, out_tag and out_violation are visible in cycle N+2. Total latency 2 cycles. Back-to-back requests give back-to-back results; no stall.
- load_select 3: no out_valid and no violation. See the optional feature for the alternative.
- Clearance: cfg_we at cycle M updates the register at the edge ending M. It affects stage-2 evaluations in cycles M+1 onward.
- viol_count increments on every violation, including those during TRAP. It saturates at all-ones.
- FSM IDLE:
  - A violation loads trap_addr and trap_tag, sets trap_req = 1 (visible with out_valid) and moves to TRAP.
- FSM TRAP:
  - trap_req, trap_addr and trap_tag are held stable until trap_ack is sampled high.
  - trap_ack without a new violation: clear trap_req and trap_overflow; next state IDLE.
  - trap_ack together with a new violation in the same cycle: capture the new violation, clear trap_overflow, stay in TRAP.
  - New violation without trap_ack: trap data unchanged; trap_overflow set (sticky).
- trap_ack in IDLE is ignored.

Optional Feature:
- Macro TAG_CHECK_STRICT_EN.
- Defined: a request with load_select 3 produces a result in cycle N+2 with out_valid=1, out_tag=6'h00 and out_violation=1. It is treated as a violation with trap_tag=6'h3F: it enters the FSM and increments viol_count.
- Not defined: load_select 3 requests are silently dropped.

Test Plan:
- Reset, clearance 6'h3F; word request addr 0x010, tags 01/02/04/08 -> out_valid in cycle N+2, out_tag=6'h0F, out_violation=0, trap_req=0.
- Write clearance 6'h03; halfword request addr 0x020, tags 01/04 (lanes 3/4 = 3F) -> out_tag=6'h05, violation=1, trap_req=1, trap_addr=0x020, trap_tag=6'h04, viol_count=1.
- While in TRAP, byte request with tag 6'h10 -> trap data unchanged, trap_overflow=1, viol_count=2. Then trap_ack -> trap_req=0, trap_overflow=0 next cycle.
- trap_ack asserted in the same cycle as a new violation (addr 0x030, tag 6'h20) -> stays TRAP, trap_addr=0x030, trap_tag=6'h20.
- COUNT_W=2, five violations -> viol_count stays at 3. rst asserted with a request in stage 1 -> no out_valid follows, all outputs 0.
- load_select 3 at addr 0x040 -> no out_valid without the macro. With TAG_CHECK_STRICT_EN: out_violation=1, trap_tag=6'h3F.
